mem_requester: RTL and testbench
================================

MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 Parameter RSP_WAIT, default 24: cycles from batch issue to response sampling; must exceed memory latency (21 cycles + 2 pipeline).
REQ-002 Parameter GAP_CYCLES, default 2: minimum cycles mem_en held 0 between consecutive batches.
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 req_valid  input  1  host request present.
REQ-006 req_ready  output  1  block idle, request accepted when req_valid & req_ready.
REQ-007 req_rdwr  input  1  1 = read, 0 = write.
REQ-008 req_addr  input  64  byte base address.
REQ-009 req_len  input  7  byte count, 0..64.
REQ-010 wd_valid / wd_ready  input / output  1 / 1  write-data handshake, one 8-byte beat per batch.
REQ-011 wd_data  input  [7:0][7:0]  write bytes; lane i to address base+8k+i.
REQ-012 rsp_valid  output  1  one-cycle pulse per read batch.
REQ-013 rsp_data  output  [7:0][7:0]  read bytes; rsp_mask  output  8  valid lanes; rsp_last  output  1  final batch.
REQ-014 done  output  1  one-cycle pulse at request completion; err  output  1  sticky read-lane error, cleared on next accept.
REQ-015 mem_en  output  8  per-lane enable; mem_rdwr  output  1; mem_addr  output  [7:0][63:0]; mem_wdata  output  [7:0][7:0].
REQ-016 mem_rdata  input  [7:0][7:0]; mem_valid  input  8  per-lane read-valid from memory.

Function
REQ-017 States: IDLE, WDATA, ISSUE, GAP, DONE; req_ready SHALL be 1 only in IDLE.
REQ-018 Accept: latch addr, len, rdwr; clear err; batch index k=0; remaining = len.
REQ-019 len=0: IDLE -> DONE, done pulses next cycle, mem_en stays 0, no rsp_valid.
REQ-020 Batch mask: remaining>=8 -> 8'hFF, else (1<<remaining)-1; lane i address = base + 8k + i, 64-bit add wrapping modulo 2^64.
REQ-021 Write: enter WDATA, wd_ready=1 until wd_valid; capture wd_data into mem_wdata, then ISSUE.
REQ-022 Read: enter ISSUE directly from IDLE/GAP.
REQ-023 ISSUE: mem_en=mask, mem_rdwr, mem_addr, mem_wdata held constant every cycle of ISSUE; counter counts 0..RSP_WAIT-1.
REQ-024 At count RSP_WAIT-1 (read): rsp_valid=1 for one cycle with rsp_data=mem_rdata, rsp_mask=mask, rsp_last=(remaining<=8); err set if (mem_valid & mask) != mask.
REQ-025 At count RSP_WAIT-1 (either): remaining -= popcount(mask), k+=1; remaining=0 -> DONE else GAP.
REQ-026 GAP: mem_en=0 for exactly GAP_CYCLES cycles, then WDATA (write) or ISSUE (read).
REQ-027 DONE: done=1 one cycle, mem_en=0, then IDLE.
REQ-028 mem_en SHALL be 0 in IDLE, WDATA, GAP, DONE; wd_ready 0 outside WDATA.
REQ-029 req_valid while busy ignored; req_* sampled only at accept.
REQ-030 Throughput: batch occupies RSP_WAIT cycles plus GAP_CYCLES (plus WDATA wait for writes).

Reset
REQ-031 Reset SHALL force IDLE; req_ready=1; mem_en=0, mem_rdwr=0, mem_addr=0, mem_wdata=0; wd_ready=0; rsp_valid=0, rsp_data=0, rsp_mask=0, rsp_last=0; done=0; err=0; counters 0.
REQ-032 Reset mid-transaction abandons it: no done, no rsp_valid; outputs at reset values the cycle after reset sampled.

Verification
REQ-033 Read len=8 addr=0x10, memory preloaded -> mem_en=FF for RSP_WAIT cycles, addrs 0x10..0x17, one rsp_valid mask=FF rsp_last=1, done next cycle, err=0.
REQ-034 Write len=11 addr=0x20 -> two wd handshakes; batch0 mask=FF addrs 0x20..0x27, GAP of 2 cycles mem_en=0, batch1 mask=07 addrs 0x28..0x2A; done once; readback matches.
REQ-035 len=0 -> done two cycles after accept, mem_en never nonzero.
REQ-036 Read addr=0xFFFF_FFFF_FFFF_FFFC len=8 -> lane addresses wrap to 0x0..0x3 on lanes 4..7.
REQ-037 Read with memory model forcing mem_valid lane 3 low -> rsp_valid delivered, err=1 until next accept.
REQ-038 Reset asserted mid-ISSUE of 3-batch read -> next cycle mem_en=0, req_ready=1, no done/rsp_valid; new request completes normally.

Source files
------------

// File: rtl/mem_requester_if.sv
// Host-side request/write-data/response signals and the 8-lane memory port of mem_requester.
interface mem_requester_if;
    // Host request
    logic             req_valid;
    logic             req_ready;
    logic             req_rdwr;
    logic [63:0]      req_addr;
    logic [6:0]       req_len;
    // Write data, one 8-byte beat per batch
    logic             wd_valid;
    logic             wd_ready;
    logic [7:0][7:0]  wd_data;
    // Read response and completion
    logic             rsp_valid;
    logic [7:0][7:0]  rsp_data;
    logic [7:0]       rsp_mask;
    logic             rsp_last;
    logic             done;
    logic             err;
    // Per-lane memory port
    logic [7:0]       mem_en;
    logic             mem_rdwr;
    logic [7:0][63:0] mem_addr;
    logic [7:0][7:0]  mem_wdata;
    logic [7:0][7:0]  mem_rdata;
    logic [7:0]       mem_valid;

    // Host and memory side (drives requests, write data and memory read returns)
    modport master (
        output req_valid, req_rdwr, req_addr, req_len,
        output wd_valid, wd_data,
        output mem_rdata, mem_valid,
        input  req_ready, wd_ready,
        input  rsp_valid, rsp_data, rsp_mask, rsp_last, done, err,
        input  mem_en, mem_rdwr, mem_addr, mem_wdata
    );

    // The requester block itself
    modport slave (
        input  req_valid, req_rdwr, req_addr, req_len,
        input  wd_valid, wd_data,
        input  mem_rdata, mem_valid,
        output req_ready, wd_ready,
        output rsp_valid, rsp_data, rsp_mask, rsp_last, done, err,
        output mem_en, mem_rdwr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_requester.sv
// Splits a host byte request (0..64 bytes) into 8-lane memory batches. Each batch
// holds the memory port steady for RSP_WAIT cycles, samples read data on the last
// cycle, then idles the port for GAP_CYCLES before the next batch.
// GAP_CYCLES must be at least 1 and RSP_WAIT must exceed the memory latency.
module mem_requester #(
    parameter int unsigned RSP_WAIT   = 24,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_requester_if.slave bus
);
    localparam int unsigned LANES   = 8;
    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned LEN_W   = 7;
    localparam int unsigned BATCH_W = 4;
    localparam int unsigned CNT_MAX = (RSP_WAIT > GAP_CYCLES) ? RSP_WAIT : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WDATA = 3'd1,
        S_ISSUE = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Lane-enable mask for a batch given the bytes still outstanding
    function automatic logic [LANES-1:0] mask_of(input logic [LEN_W-1:0] rem);
        if (rem >= LEN_W'(LANES)) begin
            return '1;
        end
        return LANES'((9'd1 << rem[2:0]) - 9'd1);
    endfunction

    state_t                       r_state;
    state_t                       w_next_state;

    // Request context
    logic [ADDR_W-1:0]            r_base;
    logic                         r_rdwr;
    logic [BATCH_W-1:0]           r_k;
    logic [LEN_W-1:0]             r_rem;
    logic [CNT_W-1:0]             r_count;

    // Registered outputs
    logic                         r_req_ready;
    logic                         r_wd_ready;
    logic [LANES-1:0]             r_mem_en;
    logic                         r_mem_rdwr;
    logic [LANES-1:0][ADDR_W-1:0] r_mem_addr;
    logic [LANES-1:0][7:0]        r_mem_wdata;
    logic                         r_rsp_valid;
    logic [LANES-1:0][7:0]        r_rsp_data;
    logic [LANES-1:0]             r_rsp_mask;
    logic                         r_rsp_last;
    logic                         r_done;
    logic                         r_err;

    // Events and batch arithmetic
    logic                         w_accept;
    logic                         w_wd_fire;
    logic                         w_batch_end;
    logic                         w_gap_end;
    logic [LEN_W-1:0]             w_take;
    logic [LEN_W-1:0]             w_rem_after;
    logic [LANES-1:0]             w_mask_cur;

    // Next values
    logic [ADDR_W-1:0]            w_base_nxt;
    logic                         w_rdwr_nxt;
    logic [BATCH_W-1:0]           w_k_nxt;
    logic [LEN_W-1:0]             w_rem_nxt;
    logic [CNT_W-1:0]             w_count_nxt;
    logic [LANES-1:0]             w_mask_nxt;
    logic [LANES-1:0][ADDR_W-1:0] w_addr_nxt;
    logic                         w_req_ready_nxt;
    logic                         w_wd_ready_nxt;
    logic [LANES-1:0]             w_mem_en_nxt;
    logic                         w_mem_rdwr_nxt;
    logic [LANES-1:0][ADDR_W-1:0] w_mem_addr_nxt;
    logic [LANES-1:0][7:0]        w_mem_wdata_nxt;
    logic                         w_rsp_valid_nxt;
    logic [LANES-1:0][7:0]        w_rsp_data_nxt;
    logic [LANES-1:0]             w_rsp_mask_nxt;
    logic                         w_rsp_last_nxt;
    logic                         w_done_nxt;
    logic                         w_err_nxt;

    assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
    assign w_wd_fire   = (r_state == S_WDATA) && bus.wd_valid;
    assign w_batch_end = (r_state == S_ISSUE) && (r_count == CNT_W'(RSP_WAIT - 1));
    assign w_gap_end   = (r_state == S_GAP) && (r_count == CNT_W'(GAP_CYCLES - 1));
    assign w_take      = (r_rem >= LEN_W'(LANES)) ? LEN_W'(LANES) : r_rem;
    assign w_rem_after = r_rem - w_take;
    assign w_mask_cur  = mask_of(r_rem);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.req_len == '0) begin
                        w_next_state = S_DONE;
                    end else if (bus.req_rdwr) begin
                        w_next_state = S_ISSUE;
                    end else begin
                        w_next_state = S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                if (w_wd_fire) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_batch_end) begin
                    w_next_state = (w_rem_after == '0) ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_next_state = r_rdwr ? S_ISSUE : S_WDATA;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values; memory port values follow the state being entered
    always_comb begin
        w_base_nxt      = r_base;
        w_rdwr_nxt      = r_rdwr;
        w_k_nxt         = r_k;
        w_rem_nxt       = r_rem;
        w_count_nxt     = '0;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_mask_nxt  = r_rsp_mask;
        w_rsp_last_nxt  = r_rsp_last;
        w_err_nxt       = r_err;
        w_mem_en_nxt    = '0;
        w_mem_rdwr_nxt  = r_mem_rdwr;
        w_mem_addr_nxt  = r_mem_addr;

        if (w_accept) begin
            w_base_nxt = bus.req_addr;
            w_rdwr_nxt = bus.req_rdwr;
            w_k_nxt    = '0;
            w_rem_nxt  = bus.req_len;
            w_err_nxt  = 1'b0;
        end

        if (w_wd_fire) begin
            w_mem_wdata_nxt = bus.wd_data;
        end

        if (w_batch_end) begin
            w_k_nxt   = r_k + BATCH_W'(1);
            w_rem_nxt = w_rem_after;
            if (r_rdwr) begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_data_nxt  = bus.mem_rdata;
                w_rsp_mask_nxt  = w_mask_cur;
                w_rsp_last_nxt  = (r_rem <= LEN_W'(LANES));
                if ((bus.mem_valid & w_mask_cur) != w_mask_cur) begin
                    w_err_nxt = 1'b1;
                end
            end
        end

        if ((w_next_state == r_state) && ((r_state == S_ISSUE) || (r_state == S_GAP))) begin
            w_count_nxt = r_count + CNT_W'(1);
        end

        // Lane i sits at base + 8k + i; the concatenation is exactly 8k + i
        w_mask_nxt = mask_of(w_rem_nxt);
        for (int unsigned i = 0; i < LANES; i++) begin
            w_addr_nxt[i] = w_base_nxt + ADDR_W'({w_k_nxt, 3'(i)});
        end

        if (w_next_state == S_ISSUE) begin
            w_mem_en_nxt   = w_mask_nxt;
            w_mem_rdwr_nxt = w_rdwr_nxt;
            w_mem_addr_nxt = w_addr_nxt;
        end

        w_req_ready_nxt = (w_next_state == S_IDLE);
        w_wd_ready_nxt  = (w_next_state == S_WDATA);
        w_done_nxt      = (r_state == S_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base      <= '0;
            r_rdwr      <= 1'b0;
            r_k         <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            r_req_ready <= 1'b1;
            r_wd_ready  <= 1'b0;
            r_mem_en    <= '0;
            r_mem_rdwr  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_mask  <= '0;
            r_rsp_last  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_base      <= w_base_nxt;
            r_rdwr      <= w_rdwr_nxt;
            r_k         <= w_k_nxt;
            r_rem       <= w_rem_nxt;
            r_count     <= w_count_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_wd_ready  <= w_wd_ready_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_rdwr  <= w_mem_rdwr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_mask  <= w_rsp_mask_nxt;
            r_rsp_last  <= w_rsp_last_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.wd_ready  = r_wd_ready;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_rdwr  = r_mem_rdwr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_mask  = r_rsp_mask;
    assign bus.rsp_last  = r_rsp_last;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: byte-addressed memory model with fixed read latency,
// a bus monitor, and a reference of expected batches/responses/timing.
module tb_mem_requester;
    localparam int unsigned RSP_WAIT   = 24;
    localparam int unsigned GAP_CYCLES = 2;
    localparam int          MEM_LAT    = 23;

    logic clk = 1'b0;
    logic reset;
    mem_requester_if bus();

    mem_requester #(.RSP_WAIT(RSP_WAIT), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: DUT-written model, and the bench's own expectation
    logic [7:0] mdl_mem [logic [63:0]];
    logic [7:0] ref_mem [logic [63:0]];
    bit         bad3   = 1'b0;
    int         en_cnt = 0;

    function automatic logic [7:0] init_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mdl_rd(input logic [63:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // Memory model: writes land every enabled cycle, read data valid after MEM_LAT enabled cycles
    always @(negedge clk) begin
        if (bus.mem_en != 8'h00) en_cnt++;
        else en_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.mem_en[i] && !bus.mem_rdwr) mdl_mem[bus.mem_addr[i]] = bus.mem_wdata[i];
            if (bus.mem_en[i] && en_cnt >= MEM_LAT) begin
                bus.mem_rdata[i] = mdl_rd(bus.mem_addr[i]);
                bus.mem_valid[i] = !(bad3 && i == 3);
            end else begin
                bus.mem_rdata[i] = 8'hA5;
                bus.mem_valid[i] = 1'b0;
            end
        end
    end

    typedef struct {
        logic [7:0]  mask;
        logic        rdwr;
        logic [7:0][63:0] addr;
        logic [63:0] wdata;
        int          len;
        int          start;
        bit          hold_bad;
    } batch_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  mask;
        logic        last;
        logic        err;
        int          cyc;
    } rsp_t;

    batch_t     batches[$];
    batch_t     cur_b;
    rsp_t       rsps[$];
    int         gaps[$];
    int         gap_run  = -1;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         viol     = 0;
    logic [7:0] prev_en  = 8'h00;

    // Bus monitor: records batches, idle gaps between them, responses and done pulses
    always @(negedge clk) begin
        rsp_t r;
        if (bus.mem_en != 8'h00) begin
            if (prev_en == 8'h00) begin
                if (gap_run >= 0) gaps.push_back(gap_run);
                gap_run        = -1;
                cur_b.mask     = bus.mem_en;
                cur_b.rdwr     = bus.mem_rdwr;
                cur_b.addr     = bus.mem_addr;
                cur_b.wdata    = bus.mem_wdata;
                cur_b.len      = 1;
                cur_b.start    = cyc;
                cur_b.hold_bad = 1'b0;
            end else begin
                cur_b.len++;
                if (bus.mem_en != cur_b.mask || bus.mem_rdwr != cur_b.rdwr ||
                    bus.mem_addr != cur_b.addr || bus.mem_wdata != cur_b.wdata)
                    cur_b.hold_bad = 1'b1;
            end
            if (bus.wd_ready || bus.req_ready || bus.done || bus.rsp_valid) viol++;
        end else begin
            if (prev_en != 8'h00) begin
                batches.push_back(cur_b);
                gap_run = 0;
            end
            if (gap_run >= 0) gap_run++;
        end
        if (bus.rsp_valid) begin
            r.data = bus.rsp_data;
            r.mask = bus.rsp_mask;
            r.last = bus.rsp_last;
            r.err  = bus.err;
            r.cyc  = cyc;
            rsps.push_back(r);
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.wd_ready && bus.req_ready) viol++;
        prev_en = bus.mem_en;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        batches.delete();
        rsps.delete();
        gaps.delete();
        gap_run  = -1;
        done_cnt = 0;
        viol     = 0;
    endtask

    // One host request with full check of batches, responses, gaps and completion
    task automatic do_req(input bit rd, input logic [63:0] addr, input int len, input bit b3,
                          input string tag);
        int          nb;
        int          acc;
        int          budget;
        int          rem;
        int          nbad;
        logic [63:0] sent [8];
        logic [7:0]  exp_mask;
        logic [63:0] ea;
        bit          exp_err;
        int          last_start;

        nb   = (len + 7) / 8;
        bad3 = b3;
        clear_mon();
        budget = 0;
        while (!bus.req_ready && budget < 100) begin
            step();
            budget++;
        end
        bus.req_valid = 1'b1;
        bus.req_rdwr  = rd;
        bus.req_addr  = addr;
        bus.req_len   = 7'(len);
        acc = cyc;
        step();
        // Request fields change and req_valid stays high for a while: both must be ignored
        bus.req_addr = {$urandom, $urandom};
        bus.req_len  = 7'($urandom_range(0, 64));
        bus.req_rdwr = 1'($urandom_range(0, 1));
        if (rd && len > 0) repeat (5) step();
        bus.req_valid = 1'b0;

        if (!rd) begin
            for (int b = 0; b < nb; b++) begin
                budget = 0;
                while (!bus.wd_ready && budget < 200) begin
                    step();
                    budget++;
                end
                chk($sformatf("%s wd_ready b%0d", tag, b), 64'(bus.wd_ready), 64'd1);
                repeat ($urandom_range(0, 2)) step();
                sent[b]       = {$urandom, $urandom};
                bus.wd_valid  = 1'b1;
                bus.wd_data   = sent[b];
                step();
                bus.wd_valid  = 1'b0;
                bus.wd_data   = {$urandom, $urandom};
                rem = len - 8 * b;
                for (int i = 0; i < 8 && i < rem; i++)
                    ref_mem[addr + 64'(8 * b + i)] = sent[b][8*i +: 8];
            end
        end

        budget = 0;
        while (done_cnt == 0 && budget < 600) begin
            step();
            budget++;
        end
        repeat (3) step();

        chk({tag, " done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, " n_batches"}, 64'(batches.size()), 64'(nb));
        chk({tag, " n_rsp"}, 64'(rsps.size()), rd ? 64'(nb) : 64'd0);
        chk({tag, " port_viol"}, 64'(viol), 64'd0);
        chk({tag, " n_gaps"}, 64'(gaps.size()), (nb > 0) ? 64'(nb - 1) : 64'd0);

        exp_err    = 1'b0;
        last_start = acc - RSP_WAIT + 1;
        for (int b = 0; b < nb && b < batches.size(); b++) begin
            rem      = len - 8 * b;
            exp_mask = 8'h00;
            for (int i = 0; i < 8 && i < rem; i++) exp_mask[i] = 1'b1;
            chk($sformatf("%s b%0d mask", tag, b), 64'(batches[b].mask), 64'(exp_mask));
            chk($sformatf("%s b%0d rdwr", tag, b), 64'(batches[b].rdwr), 64'(rd));
            chk($sformatf("%s b%0d dur", tag, b), 64'(batches[b].len), 64'(RSP_WAIT));
            chk($sformatf("%s b%0d hold", tag, b), 64'(batches[b].hold_bad), 64'd0);
            nbad = 0;
            for (int i = 0; i < 8; i++) begin
                ea = addr + 64'(8 * b + i);
                if (exp_mask[i] && batches[b].addr[i] !== ea) nbad++;
            end
            chk($sformatf("%s b%0d bad_addr_lanes", tag, b), 64'(nbad), 64'd0);
            if (!rd) chk($sformatf("%s b%0d wdata", tag, b), batches[b].wdata, sent[b]);
            if (rd) chk($sformatf("%s b%0d start", tag, b), 64'(batches[b].start),
                        64'(acc + 1 + b * (RSP_WAIT + GAP_CYCLES)));
            last_start = batches[b].start;
            if (rd && b < rsps.size()) begin
                if (b3 && exp_mask[3]) exp_err = 1'b1;
                chk($sformatf("%s r%0d mask", tag, b), 64'(rsps[b].mask), 64'(exp_mask));
                chk($sformatf("%s r%0d last", tag, b), 64'(rsps[b].last), 64'(b == nb - 1));
                chk($sformatf("%s r%0d err", tag, b), 64'(rsps[b].err), 64'(exp_err));
                chk($sformatf("%s r%0d cyc", tag, b), 64'(rsps[b].cyc),
                    64'(batches[b].start + RSP_WAIT));
                nbad = 0;
                for (int i = 0; i < 8; i++)
                    if (exp_mask[i] && rsps[b].data[8*i +: 8] !== ref_rd(addr + 64'(8 * b + i)))
                        nbad++;
                chk($sformatf("%s r%0d bad_data_lanes", tag, b), 64'(nbad), 64'd0);
            end
        end
        for (int g = 0; g < gaps.size(); g++) begin
            if (rd) chk($sformatf("%s gap%0d", tag, g), 64'(gaps[g]), 64'(GAP_CYCLES));
            else    chk($sformatf("%s gap%0d_min", tag, g), 64'(gaps[g] >= GAP_CYCLES + 1), 64'd1);
        end
        if (nb == 0) chk({tag, " done_cyc"}, 64'(done_cyc), 64'(acc + 2));
        else         chk({tag, " done_cyc"}, 64'(done_cyc), 64'(last_start + RSP_WAIT + 1));
        chk({tag, " err_end"}, 64'(bus.err), 64'(exp_err));
    endtask

    initial begin
        int          rd;
        int          len;
        logic [63:0] addr;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_rdwr  = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.wd_valid  = 1'b0;
        bus.wd_data   = '0;
        bus.mem_rdata = '0;
        bus.mem_valid = '0;
        repeat (3) step();

        chk("rst req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst mem_en", 64'(bus.mem_en), 64'd0);
        chk("rst mem_addr0", bus.mem_addr[0], 64'd0);
        chk("rst mem_wdata", bus.mem_wdata, 64'd0);
        chk("rst wd_ready", 64'(bus.wd_ready), 64'd0);
        chk("rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst rsp_data", bus.rsp_data, 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst err", 64'(bus.err), 64'd0);
        reset = 1'b0;
        step();

        do_req(1'b1, 64'h10, 8, 1'b0, "rd8");
        do_req(1'b0, 64'h20, 11, 1'b0, "wr11");
        do_req(1'b1, 64'h20, 11, 1'b0, "rb11");
        do_req(1'b1, 64'h40, 0, 1'b0, "len0_rd");
        do_req(1'b0, 64'h40, 0, 1'b0, "len0_wr");
        do_req(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 8, 1'b0, "wrap");
        chk("wrap lane4", batches.size() > 0 ? batches[0].addr[4] : 64'hDEAD, 64'h0);
        chk("wrap lane7", batches.size() > 0 ? batches[0].addr[7] : 64'hDEAD, 64'h3);
        do_req(1'b1, 64'h100, 13, 1'b1, "bad3");
        repeat (5) step();
        chk("bad3 err_sticky", 64'(bus.err), 64'd1);
        do_req(1'b1, 64'h200, 5, 1'b0, "after_bad3");

        // Reset in the middle of the first batch of a 3-batch read
        clear_mon();
        bus.req_valid = 1'b1;
        bus.req_rdwr  = 1'b1;
        bus.req_addr  = 64'h1000;
        bus.req_len   = 7'd24;
        step();
        bus.req_valid = 1'b0;
        repeat (10) step();
        chk("midrst en_before", 64'(bus.mem_en), 64'hFF);
        reset = 1'b1;
        step();
        chk("midrst mem_en", 64'(bus.mem_en), 64'd0);
        chk("midrst req_ready", 64'(bus.req_ready), 64'd1);
        chk("midrst rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midrst done", 64'(bus.done), 64'd0);
        chk("midrst mem_addr0", bus.mem_addr[0], 64'd0);
        reset = 1'b0;
        repeat (60) step();
        chk("midrst no_rsp", 64'(rsps.size()), 64'd0);
        chk("midrst no_done", 64'(done_cnt), 64'd0);
        do_req(1'b1, 64'h1000, 24, 1'b0, "postrst");

        // Randomized requests; every write is read back
        for (int t = 0; t < 12; t++) begin
            rd  = $urandom_range(0, 1);
            len = $urandom_range(0, 64);
            if ($urandom_range(0, 3) == 0) addr = {32'hFFFF_FFFF, 32'hFFFF_FFC0 | 32'($urandom_range(0, 63))};
            else                          addr = {32'h0, 32'($urandom_range(0, 4095))};
            do_req(rd[0], addr, len, 1'b0, $sformatf("rnd%0d", t));
            if (rd == 0) do_req(1'b1, addr, len, 1'b0, $sformatf("rnd%0d_rb", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
